// File: rtl/vga_frame_pkg.sv
// Shared 640x480@60 timing defaults, digit blank code and the digit-update handshake states
// for the VGA frame controller slice.
package vga_frame_pkg;

    localparam int H_VIS_D = 640;
    localparam int H_FP_D  = 16;
    localparam int H_SW_D  = 96;
    localparam int H_TOT_D = 800;
    localparam int V_VIS_D = 480;
    localparam int V_FP_D  = 10;
    localparam int V_SW_D  = 2;
    localparam int V_TOT_D = 525;

    localparam int CNT_W = 11;
    localparam int DIG_N = 6;
    localparam int DIG_W = 4 * DIG_N;

    localparam logic [3:0]       BLANK      = 4'hF;
    localparam logic [DIG_W-1:0] DIGITS_RST = {DIG_N{BLANK}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_HOLD
    } upd_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; wrap flags the advancing cycle
// that takes the count from TOTAL-1 back to 0.
module vga_axis_counter
    import vga_frame_pkg::*;
#(
    parameter int TOTAL = H_TOT_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;

    assign wrap  = inc && (r_count == LAST);
    assign count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (wrap) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA raster timing generator with a frame-synchronous digit update handshake:
// new BCD digits are only taken on the wrap into (0,0) so a frame never shows mixed digits.
module vga_frame_ctrl
    import vga_frame_pkg::*;
#(
    parameter int H_VIS = H_VIS_D,
    parameter int H_FP  = H_FP_D,
    parameter int H_SW  = H_SW_D,
    parameter int H_TOT = H_TOT_D,
    parameter int V_VIS = V_VIS_D,
    parameter int V_FP  = V_FP_D,
    parameter int V_SW  = V_SW_D,
    parameter int V_TOT = V_TOT_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIG_W-1:0] digits_in,
    input  logic             upd_req,
    output logic             upd_ack,
    output logic [DIG_W-1:0] digits_out,
    output logic [CNT_W-1:0] counth,
    output logic [CNT_W-1:0] countv,
    output logic             h_sinc,
    output logic             v_sinc,
    // visible-area flag; "inside" itself is a reserved word
    output logic             inside_vis,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SW);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SW);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_v_inc;

    logic             r_hs;
    logic             r_vs;
    logic             r_inside;
    logic             r_fs;
    logic             r_ack;
    logic [DIG_W-1:0] r_digits;
    upd_state_t       r_state;

    function automatic logic [DIG_W-1:0] blank_invalid(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] res;
        res = d;
        for (int i = 0; i < DIG_N; i++) begin
            if (d[i*4 +: 4] > 4'd9) begin
                res[i*4 +: 4] = BLANK;
            end
        end
        return res;
    endfunction

    assign w_v_inc = en && w_h_wrap;

    vga_axis_counter #(.TOTAL(H_TOT)) u_hcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (en),
        .count (w_h_cnt),
        .wrap  (w_h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOT)) u_vcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_v_inc),
        .count (w_v_cnt),
        .wrap  (w_v_wrap)
    );

    // Decoding the post-edge position keeps the registered flags aligned with the counts.
    assign w_h_nxt = w_h_wrap ? '0 : (en      ? w_h_cnt + 1'b1 : w_h_cnt);
    assign w_v_nxt = w_v_wrap ? '0 : (w_v_inc ? w_v_cnt + 1'b1 : w_v_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_inside <= 1'b1;
            r_fs     <= 1'b0;
        end else if (en) begin
            r_hs     <= !((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END));
            r_vs     <= !((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END));
            r_inside <= (w_h_nxt < H_VIS_C) && (w_v_nxt < V_VIS_C);
            r_fs     <= w_v_wrap;
        end else begin
            // a frozen raster must not stretch or repeat the frame pulse
            r_fs     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ack    <= 1'b0;
            r_digits <= DIGITS_RST;
        end else if (!en) begin
            r_ack    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (upd_req) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!upd_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_v_wrap) begin
                        r_state  <= ST_ACK;
                        r_ack    <= 1'b1;
                        r_digits <= blank_invalid(digits_in);
                    end
                end
                ST_ACK: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!upd_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign counth      = w_h_cnt;
    assign countv      = w_v_cnt;
    assign h_sinc      = r_hs;
    assign v_sinc      = r_vs;
    assign inside_vis  = r_inside;
    assign frame_start = r_fs;
    assign upd_ack     = r_ack;
    assign digits_out  = r_digits;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl on a shrunken 32x12 raster so full frames stay short.
module tb_vga_frame_ctrl;

    localparam int HV = 20;
    localparam int HF = 3;
    localparam int HS = 5;
    localparam int HT = 32;
    localparam int VV = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VT = 12;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [23:0] digits_in;
    logic        upd_req;
    logic        upd_ack;
    logic [23:0] digits_out;
    logic [10:0] counth;
    logic [10:0] countv;
    logic        h_sinc;
    logic        v_sinc;
    logic        inside_vis;
    logic        frame_start;

    int n_cmp = 0;
    int n_mis = 0;
    int n_ack = 0;
    int k, ech, ecv, hs_low, vs_low, in_cnt, fs_cnt, last_fs, fs_gap, frz_bad, a0;
    logic ehs, evs, ein, efs;

    always #5 clk = ~clk;

    vga_frame_ctrl #(
        .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_TOT(HT),
        .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_TOT(VT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .digits_in   (digits_in),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .digits_out  (digits_out),
        .counth      (counth),
        .countv      (countv),
        .h_sinc      (h_sinc),
        .v_sinc      (v_sinc),
        .inside_vis  (inside_vis),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (upd_ack) n_ack++;
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            step();
            hit = (counth == 11'(h)) && (countv == 11'(v));
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ch"},  32'(counth),      32'd0);
        check({tag, "_cv"},  32'(countv),      32'd0);
        check({tag, "_hs"},  32'(h_sinc),      32'd1);
        check({tag, "_vs"},  32'(v_sinc),      32'd1);
        check({tag, "_in"},  32'(inside_vis),  32'd1);
        check({tag, "_fs"},  32'(frame_start), 32'd0);
        check({tag, "_ack"}, 32'(upd_ack),     32'd0);
        check({tag, "_dig"}, 32'(digits_out),  32'hFFFFFF);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; upd_req = 1'b0; digits_in = '0;
        #1;
        check_reset_vals("rst");
        #3 reset = 1'b0; en = 1'b1;
        step();
        check("first_ch", 32'(counth), 32'd1);
        check("first_cv", 32'(countv), 32'd0);

        // two full frames against the raster model
        k = 1; hs_low = 0; vs_low = 0; in_cnt = 0; fs_cnt = 0; last_fs = -1; fs_gap = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            k++;
            ech = k % HT;
            ecv = (k / HT) % VT;
            ehs = !(ech >= HV + HF && ech < HV + HF + HS);
            evs = !(ecv >= VV + VF && ecv < VV + VF + VS);
            ein = (ech < HV) && (ecv < VV);
            efs = (ech == 0) && (ecv == 0);
            check("sweep", 32'({counth, countv, h_sinc, v_sinc, inside_vis, frame_start}),
                  32'({11'(ech), 11'(ecv), ehs, evs, ein, efs}));
            hs_low += int'(!h_sinc);
            vs_low += int'(!v_sinc);
            in_cnt += int'(inside_vis);
            if (frame_start) begin
                fs_cnt++;
                if (last_fs >= 0) fs_gap = k - last_fs;
                last_fs = k;
            end
        end
        check("hs_low_total", hs_low, 2 * HS * VT);
        check("vs_low_total", vs_low, 2 * VS * HT);
        check("inside_total", in_cnt, 2 * HV * VV);
        check("fs_count", fs_cnt, 2);
        check("fs_gap", fs_gap, FRAME);

        // basic latch: only on the frame wrap, ack one cycle later
        run_to(10, 3, "reach_10_3");
        digits_in = 24'h123456; upd_req = 1'b1;
        run_to(HT - 1, VT - 1, "reach_wrap_a");
        check("pre_wrap_dig", 32'(digits_out), 32'hFFFFFF);
        check("pre_wrap_acks", n_ack, 0);
        step();
        check("wrap_pos", 32'({counth, countv}), 32'd0);
        check("latch_dig", 32'(digits_out), 32'h123456);
        check("latch_ack", 32'(upd_ack), 32'd1);
        check("latch_fs", 32'(frame_start), 32'd1);
        step();
        check("ack_drop", 32'(upd_ack), 32'd0);
        check("ack_count_a", n_ack, 1);
        upd_req = 1'b0; step(); step();

        // out-of-range digits blanked
        digits_in = 24'h1A9B0C; upd_req = 1'b1;
        run_to(0, 0, "reach_wrap_b");
        check("blank_dig", 32'(digits_out), 32'h1F9F0F);
        check("blank_ack", 32'(upd_ack), 32'd1);
        upd_req = 1'b0; step(); step();

        // request held for several frames after ack: single latch
        a0 = n_ack;
        digits_in = 24'h654321; upd_req = 1'b1;
        repeat (4 * FRAME) step();
        check("held_acks", n_ack - a0, 1);
        check("held_dig", 32'(digits_out), 32'h654321);
        digits_in = 24'h111111;
        repeat (FRAME) step();
        check("held_no_relatch", 32'(digits_out), 32'h654321);
        upd_req = 1'b0; step(); step();
        digits_in = 24'h222222; upd_req = 1'b1;
        run_to(0, 0, "reach_wrap_c");
        check("second_dig", 32'(digits_out), 32'h222222);
        check("second_acks", n_ack - a0, 2);
        upd_req = 1'b0; step(); step();

        // freeze at the last pixel with a pending request
        digits_in = 24'h333333; upd_req = 1'b1;
        run_to(HT - 1, VT - 1, "reach_last");
        en = 1'b0; frz_bad = 0; a0 = n_ack;
        for (int i = 0; i < 50; i++) begin
            step();
            if (counth != 11'(HT - 1) || countv != 11'(VT - 1) || h_sinc !== 1'b1 ||
                v_sinc !== 1'b1 || upd_ack !== 1'b0 || frame_start !== 1'b0 ||
                digits_out != 24'h222222)
                frz_bad++;
        end
        check("frozen_cycles", frz_bad, 0);
        check("frozen_acks", n_ack - a0, 0);
        en = 1'b1;
        step();
        check("thaw_pos", 32'({counth, countv}), 32'd0);
        check("thaw_dig", 32'(digits_out), 32'h333333);
        check("thaw_ack", 32'(upd_ack), 32'd1);
        en = 1'b0;
        step();
        check("hold00_fs", 32'(frame_start), 32'd0);
        check("hold00_ack", 32'(upd_ack), 32'd0);
        check("hold00_ch", 32'(counth), 32'd0);
        en = 1'b1;
        step();
        check("resume_ch", 32'(counth), 32'd1);
        check("thaw_acks", n_ack - a0, 1);
        upd_req = 1'b0; step(); step();

        // request rising on the wrap cycle waits a whole frame
        run_to(HT - 1, VT - 1, "reach_wrap_d");
        digits_in = 24'h444444; upd_req = 1'b1; a0 = n_ack;
        step();
        check("late_req_dig", 32'(digits_out), 32'h333333);
        check("late_req_ack", 32'(upd_ack), 32'd0);
        run_to(0, 0, "reach_wrap_e");
        check("late_req_dig2", 32'(digits_out), 32'h444444);
        check("late_req_ack2", n_ack - a0, 1);
        upd_req = 1'b0; step(); step();

        // request withdrawn in WAIT
        digits_in = 24'h555555; upd_req = 1'b1;
        run_to(10, 5, "reach_10_5");
        upd_req = 1'b0; a0 = n_ack;
        run_to(0, 0, "reach_wrap_f");
        step();
        check("withdraw_dig", 32'(digits_out), 32'h444444);
        check("withdraw_acks", n_ack - a0, 0);

        // async reset while waiting
        digits_in = 24'h666666; upd_req = 1'b1;
        step(); step(); step();
        #2 reset = 1'b1;
        #1;
        check_reset_vals("rst_wait");
        reset = 1'b0;
        step();
        check("rst_wait_ch1", 32'(counth), 32'd1);
        run_to(0, 0, "reach_wrap_g");
        check("rehandshake_dig", 32'(digits_out), 32'h666666);
        check("rehandshake_ack", 32'(upd_ack), 32'd1);

        // async reset while acknowledging
        #2 reset = 1'b1;
        #1;
        check_reset_vals("rst_ack");
        reset = 1'b0; upd_req = 1'b0; a0 = n_ack;
        step();
        check("rst_ack_ch1", 32'(counth), 32'd1);
        repeat (FRAME) step();
        check("rst_ack_no_ack", n_ack - a0, 0);
        check("rst_ack_dig", 32'(digits_out), 32'hFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
